// File: rtl/video_pkg.sv
// Shared types and constants for the pixel-stream Sobel stage.
// Holds luma weights, pipeline latency, pixel and gradient types.
package video_pkg;

  localparam int LAT = 4;

  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;

  typedef logic [7:0] pix_t;
  typedef logic signed [10:0] grad_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic bypass;
    pix_t r;
    pix_t g;
    pix_t b;
  } ctl_t;

  function automatic logic [15:0] luma_sum(
    input pix_t r,
    input pix_t g,
    input pix_t b
  );
    return {8'd0, COEF_R} * {8'd0, r}
         + {8'd0, COEF_G} * {8'd0, g}
         + {8'd0, COEF_B} * {8'd0, b};
  endfunction

  // (a0 + 2a1 + a2) - (b0 + 2b1 + b2), always fits 11-bit signed
  function automatic grad_t sobel_diff(
    input pix_t a0,
    input pix_t a1,
    input pix_t a2,
    input pix_t b0,
    input pix_t b1,
    input pix_t b2
  );
    logic [10:0] pa;
    logic [10:0] pb;
    pa = {3'b0, a0} + {2'b0, a1, 1'b0} + {3'b0, a2};
    pb = {3'b0, b0} + {2'b0, b1, 1'b0} + {3'b0, b2};
    return grad_t'(pa - pb);
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Simple dual-port line RAM, read-before-write, 1-clock read latency.
// Contents are deliberately not reset.
module sobel_line_buffer
  import video_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pix_t          wdata,
  input  logic [AW-1:0] raddr,
  output pix_t          rdata
);

  pix_t mem [DEPTH];

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/video_sobel_stage.sv
// RGB -> luma -> 3x3 Sobel magnitude, 4-clock fixed latency, syncs aligned.
// SOBEL_THRESH_EN: binarise the magnitude against I_thresh.
module video_sobel_stage
  import video_pkg::*;
#(
  parameter int H_RES_MAX = 2048,
  parameter int MAG_SHIFT = 0,
  parameter int VS_POL = 1
) (
  input  logic       I_pxl_clk,
  input  logic       I_rst_n,
  input  logic       I_de,
  input  logic       I_hs,
  input  logic       I_vs,
  input  logic [7:0] I_data_r,
  input  logic [7:0] I_data_g,
  input  logic [7:0] I_data_b,
  input  logic       I_bypass,
  input  logic [7:0] I_thresh,
  output logic       O_de,
  output logic       O_hs,
  output logic       O_vs,
  output logic [7:0] O_data_r,
  output logic [7:0] O_data_g,
  output logic [7:0] O_data_b
);

  localparam int CW = $clog2(H_RES_MAX);
  typedef logic [CW-1:0] col_t;
  localparam col_t COL_LAST = col_t'(H_RES_MAX - 1);

  ctl_t ctl_in;
  ctl_t ctl_q [3];
  pix_t y_in;
  logic [7:0] y_frac_unused;

  assign ctl_in = '{de: I_de, hs: I_hs, vs: I_vs,
                    bypass: I_bypass,
                    r: I_data_r, g: I_data_g, b: I_data_b};
  assign {y_in, y_frac_unused} = luma_sum(I_data_r, I_data_g, I_data_b);

  col_t col_cnt, col1, col2;
  logic ovf_cnt, ovf1, ovf2;
  logic [11:0] row_cnt, row1, row2;
  pix_t y1, y2, lb0_rd, lb1_rd;
  logic vs_edge, de_fall;

  assign vs_edge = (I_vs == 1'(VS_POL)) && (ctl_q[0].vs != 1'(VS_POL));
  assign de_fall = ctl_q[0].de && !I_de;

  // ovf_cnt marks pixels past the last addressable column
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ctl_q[0] <= '0;
      y1       <= '0;
      col1     <= '0;
      ovf1     <= 1'b0;
      row1     <= '0;
      col_cnt  <= '0;
      ovf_cnt  <= 1'b0;
      row_cnt  <= '0;
    end else begin
      ctl_q[0] <= ctl_in;
      y1       <= y_in;
      col1     <= col_cnt;
      ovf1     <= ovf_cnt;
      row1     <= row_cnt;
      if (I_de) begin
        if (col_cnt == COL_LAST) ovf_cnt <= 1'b1;
        else col_cnt <= col_cnt + col_t'(1);
      end else begin
        col_cnt <= '0;
        ovf_cnt <= 1'b0;
      end
      if (vs_edge) row_cnt <= '0;
      else if (de_fall && row_cnt != '1) row_cnt <= row_cnt + 12'd1;
    end
  end

  sobel_line_buffer #(.DEPTH(H_RES_MAX)) u_lb0 (
    .clk   (I_pxl_clk),
    .we    (ctl_q[0].de && !ovf1),
    .waddr (col1),
    .wdata (y1),
    .raddr (col1),
    .rdata (lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(H_RES_MAX)) u_lb1 (
    .clk   (I_pxl_clk),
    .we    (ctl_q[1].de && !ovf2),
    .waddr (col2),
    .wdata (lb0_rd),
    .raddr (col1),
    .rdata (lb1_rd)
  );

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ctl_q[1] <= '0;
      y2       <= '0;
      col2     <= '0;
      ovf2     <= 1'b0;
      row2     <= '0;
    end else begin
      ctl_q[1] <= ctl_q[0];
      y2       <= y1;
      col2     <= col1;
      ovf2     <= ovf1;
      row2     <= row1;
    end
  end

  // w<row>[0] = column c-2, w<row>[1] = column c-1; row 0 is oldest
  pix_t w0 [2];
  pix_t w1 [2];
  pix_t w2 [2];
  grad_t gx, gy, gx3, gy3;
  logic ok3;

  assign gx = sobel_diff(lb1_rd, lb0_rd, y2, w0[0], w1[0], w2[0]);
  assign gy = sobel_diff(w2[0], w2[1], y2, w0[0], w0[1], lb1_rd);

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ctl_q[2] <= '0;
      gx3      <= '0;
      gy3      <= '0;
      ok3      <= 1'b0;
      w0[0] <= '0; w0[1] <= '0;
      w1[0] <= '0; w1[1] <= '0;
      w2[0] <= '0; w2[1] <= '0;
    end else begin
      ctl_q[2] <= ctl_q[1];
      gx3      <= gx;
      gy3      <= gy;
      ok3      <= ctl_q[1].de && !ovf2
                  && row2 >= 12'd2 && col2 >= col_t'(2);
      if (ctl_q[1].de) begin
        w0[0] <= w0[1]; w0[1] <= lb1_rd;
        w1[0] <= w1[1]; w1[1] <= lb0_rd;
        w2[0] <= w2[1]; w2[1] <= y2;
      end
    end
  end

  logic [10:0] ax, ay;
  logic [11:0] mag;
  pix_t sat, sob;

  assign ax  = gx3[10] ? 11'(-gx3) : 11'(gx3);
  assign ay  = gy3[10] ? 11'(-gy3) : 11'(gy3);
  assign mag = ({1'b0, ax} + {1'b0, ay}) >> MAG_SHIFT;
  assign sat = (mag > 12'd255) ? 8'd255 : mag[7:0];

`ifdef SOBEL_THRESH_EN
  pix_t thr_q [3];

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      thr_q[0] <= '0;
      thr_q[1] <= '0;
      thr_q[2] <= '0;
    end else begin
      thr_q[0] <= I_thresh;
      thr_q[1] <= thr_q[0];
      thr_q[2] <= thr_q[1];
    end
  end

  assign sob = (ok3 && sat >= thr_q[2]) ? 8'hff : 8'h00;
`else
  logic thresh_unused;

  assign thresh_unused = ^I_thresh;
  assign sob = ok3 ? sat : 8'h00;
`endif

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_de     <= 1'b0;
      O_hs     <= 1'b0;
      O_vs     <= 1'b0;
      O_data_r <= '0;
      O_data_g <= '0;
      O_data_b <= '0;
    end else begin
      O_de     <= ctl_q[2].de;
      O_hs     <= ctl_q[2].hs;
      O_vs     <= ctl_q[2].vs;
      O_data_r <= ctl_q[2].bypass ? ctl_q[2].r : sob;
      O_data_g <= ctl_q[2].bypass ? ctl_q[2].g : sob;
      O_data_b <= ctl_q[2].bypass ? ctl_q[2].b : sob;
    end
  end

endmodule
